// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory access path.
//   - funct3 size codes (F3_B/H/W/BU/HU)
//   - FSM state enum for mem_access_unit
//   - default memory-mapped IO addresses
//   - lane geometry (NUM_LANES x VEC_W bits per BRAM word)
//   - funct3 legality helpers for loads and stores
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] SW_ADDR_DEF  = 32'hFFFF_FC00;
  localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_FC60;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  function automatic logic f3_legal_ld(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_legal_st(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit memory word.
//   funct3   in  size/sign code
//   lane     in  byte offset within the word (addr[1:0], already aligned)
//   st_data  in  store data (rs2)
//   ld_word  in  raw word read from memory
//   wdata    out store data replicated across lanes
//   be       out byte write enables
//   ld_data  out selected load lane, sign/zero extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] ld_data
);

  logic [NUM_LANES-1:0][VEC_W-1:0] ld_lanes;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_lanes = ld_word;
  assign ld_b     = ld_lanes[lane];
  assign ld_h     = lane[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    wdata = st_data;
    be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {NUM_LANES{st_data[7:0]}};
        be    = 4'b0001 << lane;
      end
      2'b01: begin
        wdata = {2{st_data[15:0]}};
        be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    ld_data = {{24{ld_b[7]}}, ld_b};
      F3_BU:   ld_data = {24'b0, ld_b};
      F3_H:    ld_data = {{16{ld_h[15]}}, ld_h};
      F3_HU:   ld_data = {16'b0, ld_h};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store stage against a sync-read BRAM plus
// two memory-mapped IO registers (switches read-only, LEDs read/write).
//   clk, rst_n           clock, synchronous active-low reset
//   req                  access request, taken only when busy=0
//   mem_read, mem_write  load / store qualifiers (both or neither = no-op)
//   funct3               size/sign code
//   alu_result           effective byte address
//   write_data           store data
//   switches             board switch inputs
//   busy, done           handshake: busy while in flight, done one-cycle pulse
//   load_data            extended load result, held until the next load done
//   misalign             pulse with done on a rejected misaligned access
//   ram_addr/wdata/we    BRAM write/read port, ram_rdata 1-cycle read latency
//   leds                 LED register
// Build option: MEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses;
// without it the low address bits are forced to alignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          DMEM_ADDR_W = 14,
  parameter logic [31:0] SW_ADDR     = SW_ADDR_DEF,
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            write_data,
  input  logic [15:0]            switches,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            load_data,
  output logic                   misalign,
  output logic [DMEM_ADDR_W-1:0] ram_addr,
  output logic [31:0]            ram_wdata,
  output logic [3:0]             ram_we,
  input  logic [31:0]            ram_rdata,
  output logic [15:0]            leds
);

  state_t state;

  // captured request
  logic [2:0]  p_f3;
  logic [1:0]  p_lane;
  logic        p_mis, p_bram_ld, p_ldv, p_led_we;
  logic [31:0] p_ldd;
  logic [15:0] p_led_d;

  // decode of the live request (only meaningful at accept)
  logic        rd, wr, legal, is_half, is_word, mis, go;
  logic        in_bram, is_sw, is_led;
  logic [31:0] addr;

  assign rd      = mem_read & ~mem_write;
  assign wr      = mem_write & ~mem_read;
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);
  assign legal   = rd ? f3_legal_ld(funct3) : (wr & f3_legal_st(funct3));

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis  = legal & ((is_half & alu_result[0]) | (is_word & |alu_result[1:0]));
  assign addr = alu_result;
`else
  assign mis  = 1'b0;
  assign addr = {alu_result[31:2], alu_result[1] & ~is_word,
                 alu_result[0] & ~is_half & ~is_word};
`endif

  assign go      = legal & ~mis;
  assign in_bram = (addr[31:DMEM_ADDR_W+2] == '0);
  assign is_sw   = (addr == SW_ADDR);
  assign is_led  = (addr == LED_ADDR);

  // One aligner serves both directions: live fields while idle (store lane
  // setup at accept), captured fields afterwards (load extract in RDWAIT).
  logic [2:0]  al_f3;
  logic [1:0]  al_lane;
  logic [31:0] al_wdata, al_ld;
  logic [3:0]  al_be;

  assign al_f3   = (state == IDLE) ? funct3    : p_f3;
  assign al_lane = (state == IDLE) ? addr[1:0] : p_lane;

  mem_lane_align u_align (
    .funct3  (al_f3),
    .lane    (al_lane),
    .st_data (write_data),
    .ld_word (ram_rdata),
    .wdata   (al_wdata),
    .be      (al_be),
    .ld_data (al_ld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      load_data <= '0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      leds      <= '0;
      p_f3      <= '0;
      p_lane    <= '0;
      p_mis     <= 1'b0;
      p_bram_ld <= 1'b0;
      p_ldv     <= 1'b0;
      p_ldd     <= '0;
      p_led_we  <= 1'b0;
      p_led_d   <= '0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: if (req) begin
          state     <= ACCESS;
          busy      <= 1'b1;
          p_f3      <= funct3;
          p_lane    <= addr[1:0];
          p_mis     <= mis;
          p_bram_ld <= go & rd & in_bram;
          // illegal-size loads are unmapped and return 0; rejected ones keep load_data
          p_ldv     <= rd & ~mis;
          p_ldd     <= (go & is_sw)  ? {16'b0, switches} :
                       (go & is_led) ? {16'b0, leds} : '0;
          p_led_we  <= go & wr & is_led;
          p_led_d   <= write_data[15:0];
          if (go & in_bram) ram_addr <= addr[DMEM_ADDR_W+1:2];
          if (go & wr & in_bram) begin
            ram_we    <= al_be;
            ram_wdata <= al_wdata;
          end
        end
        ACCESS: begin
          ram_we <= '0;
          if (p_bram_ld) begin
            state <= RDWAIT;
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            misalign <= p_mis;
            if (p_ldv)    load_data <= p_ldd;
            if (p_led_we) leds      <= p_led_d;
          end
        end
        RDWAIT: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          load_data <= al_ld;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int AW = 14;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu_result = '0, write_data = '0;
  logic [15:0] switches = '0;
  logic        busy, done, misalign;
  logic [31:0] load_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]  ram_we;
  logic [15:0] leds;

  always #5 clk = ~clk;

  mem_access_unit #(.DMEM_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_result(alu_result), .write_data(write_data), .switches(switches),
    .busy(busy), .done(done), .load_data(load_data), .misalign(misalign),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .leds(leds)
  );

  // BRAM with 1-cycle read latency and per-byte writes
  logic [31:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) bram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= bram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: byte-addressed memory image plus architectural registers
  logic [7:0]  mref [0:65535];
  logic [15:0] m_leds = '0;
  logic [31:0] m_ld = '0;

  int          checks = 0, fails = 0;
  int          e_lat, t0;
  logic [31:0] e_ld, e_wd;
  logic        e_mis, e_chk_ra;
  logic [3:0]  e_we;
  logic [AW-1:0] e_ra;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a_in, input logic [31:0] wd, input logic [15:0] sw);
    int n;
    logic [31:0] a, v;
    logic legal;
    e_we = '0; e_wd = '0; e_chk_ra = 1'b0; e_ra = '0; e_lat = 1; e_mis = 1'b0;
    e_ld = m_ld;
    if (rd == wr) return;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    a = a_in;
`ifdef MEM_MISALIGN_CHECK_EN
    if (legal && (a_in % n) != 0) begin e_mis = 1'b1; return; end
`else
    if (legal) a = a_in - (a_in % n);
`endif
    if (rd) begin
      v = 0;
      if (legal && a < (4 << AW)) begin
        for (int k = 0; k < n; k++) v = v | (32'(mref[a+k]) << (8*k));
        if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        e_lat = 2; e_chk_ra = 1'b1; e_ra = a[AW+1:2];
      end else if (legal && a == SW_ADDR_DEF)  v = {16'h0, sw};
      else if (legal && a == LED_ADDR_DEF)     v = {16'h0, m_leds};
      m_ld = v;
    end else if (legal) begin
      if (a < (4 << AW)) begin
        for (int k = 0; k < n; k++) begin
          mref[a+k] = wd[8*k +: 8];
          e_we = e_we | (4'b0001 << ((a % 4) + k));
        end
        e_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        e_chk_ra = 1'b1; e_ra = a[AW+1:2];
      end else if (a == LED_ADDR_DEF) m_leds = wd[15:0];
    end
    e_ld = m_ld;
  endtask

  // drive a request, let it be accepted, then scramble the inputs
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [15:0] sw);
    logic [31:0] r;
    model(rd, wr, f3, a, wd, sw);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a; write_data = wd;
    switches = sw; req = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    req = 1'b0;
    r = $urandom;
    mem_read = r[0]; mem_write = r[1]; funct3 = r[4:2]; switches = r[31:16];
    alu_result = $urandom; write_data = $urandom;
    chk("busy_accept", busy, 1);
    chk("ram_we_accept", ram_we, e_we);
    if (e_we != 0) chk("ram_wdata", ram_wdata, e_wd);
    if (e_chk_ra) chk("ram_addr", ram_addr, e_ra);
  endtask

  task automatic complete();
    int lat;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) begin lat = cyc - t0; break; end
      @(posedge clk); #1;
    end
    chk("latency", lat, e_lat);
    chk("load_data", load_data, e_ld);
    chk("misalign", misalign, e_mis);
    chk("busy_done", busy, 0);
    chk("leds", leds, m_leds);
    chk("ram_we_done", ram_we, 0);
  endtask

  initial begin
    logic [31:0] r, a;
    logic rd, wr;
    for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
    for (int i = 0; i < 65536; i++) mref[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_misalign", misalign, 0); chk("rst_load_data", load_data, 0);
    chk("rst_ram_we", ram_we, 0);  chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0); chk("rst_leds", leds, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word store / load
    issue(0, 1, F3_W, 32'h10, 32'hDEAD_BEEF, 16'h0);
    chk("sw_we", ram_we, 4'b1111);
    complete();
    issue(1, 0, F3_W, 32'h10, 32'h0, 16'h0); complete();
    chk("lw_value", load_data, 32'hDEAD_BEEF);

    // byte store and signed / unsigned byte loads
    issue(0, 1, F3_B, 32'h13, 32'h0000_0080, 16'h0);
    chk("sb_we", ram_we, 4'b1000); chk("sb_wdata", ram_wdata, 32'h8080_8080);
    complete();
    issue(1, 0, F3_B, 32'h13, 32'h0, 16'h0);  complete(); chk("lb_value", load_data, 32'hFFFF_FF80);
    issue(1, 0, F3_BU, 32'h13, 32'h0, 16'h0); complete(); chk("lbu_value", load_data, 32'h0000_0080);

    // IO registers
    issue(1, 0, F3_W, SW_ADDR_DEF, 32'h0, 16'hA5A5); complete();
    chk("sw_in_value", load_data, 32'h0000_A5A5);
    issue(0, 1, F3_W, LED_ADDR_DEF, 32'h1234_5678, 16'h0); complete();
    chk("led_value", leds, 16'h5678);
    issue(1, 0, F3_HU, LED_ADDR_DEF, 32'h0, 16'h0); complete();

    // misaligned half
    issue(0, 1, F3_H, 32'h20, 32'h0000_C3D4, 16'h0); complete();
    issue(1, 0, F3_H, 32'h21, 32'h0, 16'h0);
    chk("lh21_we", ram_we, 0);
    complete();
`ifdef MEM_MISALIGN_CHECK_EN
    chk("lh21_mis", misalign, 1);
`else
    chk("lh21_value", load_data, 32'hFFFF_C3D4);
`endif

    // no-ops, illegal sizes, unmapped
    issue(0, 0, F3_W, 32'h10, 32'h1111_1111, 16'h0); complete();
    issue(1, 1, F3_W, 32'h10, 32'h2222_2222, 16'h0); complete();
    issue(1, 0, 3'b011, 32'h10, 32'h0, 16'h0);       complete();
    issue(0, 1, F3_BU, 32'h10, 32'h3333_3333, 16'h0); complete();
    issue(1, 0, F3_W, 32'h10, 32'h0, 16'h0);         complete();
    issue(1, 0, F3_W, 32'h8000_0000, 32'h0, 16'h0);  complete();

    // request while busy must be dropped
    issue(1, 0, F3_W, 32'h10, 32'h0, 16'h0);
    req = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = F3_W;
    alu_result = LED_ADDR_DEF; write_data = 32'h0000_FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    complete();
    @(posedge clk); #1;
    chk("busy_drop", busy, 0);

    // randomized traffic, mostly back-to-back
    for (int it = 0; it < 300; it++) begin
      r = $urandom;
      rd = r[3]; wr = ~r[3];
      if (r[9:8] == 2'b00) begin rd = r[10]; wr = r[11]; end
      case (r[14:12])
        3'd5:    a = SW_ADDR_DEF;
        3'd6:    a = LED_ADDR_DEF;
        3'd7:    a = $urandom | 32'h8000_0000;
        default: a = $urandom_range(0, 255);
      endcase
      issue(rd, wr, r[2:0], a, $urandom, 16'($urandom));
      complete();
      if (r[20:18] == 3'd0) begin @(posedge clk); #1; end
    end

    // reset at E1 of a BRAM load
    issue(1, 0, F3_W, 32'h10, 32'h0, 16'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    m_leds = '0; m_ld = '0;
    chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
    chk("rst_mid_leds", leds, 0); chk("rst_mid_load_data", load_data, 0);
    chk("rst_mid_ram_we", ram_we, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_no_done", done, 0);
    end
    issue(1, 0, F3_W, 32'h10, 32'h0, 16'h0); complete();

    // final BRAM image against the reference memory
    for (int w = 0; w < 64; w++)
      chk("bram_image", bram[w], {mref[4*w+3], mref[4*w+2], mref[4*w+1], mref[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
